dsp_mul_signed_reg_accum_out_not_reg: RTL and testbench
=======================================================

// Module: dsp_mul_signed_reg_accum_out_not_reg
// PURPOSE
//   Negative-edge-triggered signed multiply-accumulate (MAC) DSP slice.
//   - Operands A and B are registered on the falling clock edge.
//   - A 38-bit accumulator adds or subtracts A_r*B_r on each falling edge.
//   - P is the accumulator register driven straight out; there is no extra output register stage.
//   - Used as a leaf DSP primitive: clean mapping of a falling-edge MAC with input registers.
// PARAMETERS
//   A_WIDTH  20  signed multiplicand width
//   B_WIDTH  18  signed multiplier width
//   P_WIDTH  38  accumulator/output width (= A_WIDTH + B_WIDTH)
// PORTS
//   clk         in   1        clock; all state updates on the falling edge
//   reset       in   1        asynchronous, active-high; clears all state
//   subtract_i  in   1        0: acc += A*B; 1: acc -= A*B
//   A           in   20       signed operand
//   B           in   18       signed operand
//   P           out  38       signed accumulator value
// BEHAVIOUR
//   - Port order is fixed: clk, reset, subtract_i, A, B, P.
//   - Interface: one clock (clk); reset is asynchronous and active-high.
//   - Reset (async assert, any time, including mid-accumulation):
//       A_r = 0, B_r = 0, sub_r = 0, acc = 0, so P = 0 immediately.
//     While reset is held, all state stays 0.
//   - Each falling clk edge while reset = 0, updates are non-blocking and simultaneous:
//       acc   <= sub_r ? acc - A_r*B_r : acc + A_r*B_r   (uses OLD A_r/B_r/sub_r)
//       A_r   <= A
//       B_r   <= B
//       sub_r <= subtract_i
//   - P = acc, combinational wire, no further register.
//   - Latency: an operand applied before falling edge N appears in P after edge N+1.
//     This is 2 falling edges from input to P.
//   - A held constant for k edges: P grows by A*B per edge once the pipeline is full.
//   - Arithmetic:
//       full-precision signed 20x18 product, 38 bits
//       accumulator add/sub is modulo 2^38, two's complement; silent wrap, no saturation, no overflow flag
//   - subtract_i is pipelined with the operands so the mode aligns with its product.
//   - Rising clk edges have no effect.
// STRUCTURE
//   - Shared package dsp_mac_pkg: A_WIDTH/B_WIDTH/P_WIDTH localparams.
//     Also typedefs a_t (logic signed [19:0]), b_t (logic signed [17:0]), p_t (logic signed [37:0]).
//   - One natural sub-module: dsp_negedge_in_reg, the async-reset falling-edge register holding A_r/B_r/sub_r.
//   - The accumulator and the add/sub mux stay in the top module.
// TESTING
//   1. Reset: A=B=0, reset=1 for 2 clk -> P=0.
//      Also assert reset mid-accumulation with no clock edge -> P=0 at once.
//   2. Add directed: release reset, subtract_i=0, A=5, B=2 applied after a falling edge.
//      After 2 falling edges -> P=10; one more edge -> P=20.
//   3. Add random: 32 falling edges with fixed random signed A, B.
//      Each edge: P(n) = P(n-1) + A*B, mod 2^38.
//   4. Subtract directed: reset with subtract_i=1, then A=5, B=2.
//      After 2 falling edges -> P=-10; next edge -> P=-20.
//   5. Subtract random: 32 edges, fixed random A, B -> P(n) = P(n-1) - A*B each edge.
//      Include negative operands, e.g. A=-524288, B=-131072 -> product +2^36.
//   6. Edge/wrap: verify no change on rising edges.
//      Toggle subtract_i mid-stream -> mode switch lands 2 edges later.
//      Accumulate A=-524288, B=-131072 past 2^37-1 -> wraps negative.

Source files
------------

// File: rtl/dsp_mac_pkg.sv
// Shared widths and operand/result types for the falling-edge signed MAC slice.
package dsp_mac_pkg;

  localparam int unsigned A_WIDTH = 20;
  localparam int unsigned B_WIDTH = 18;
  localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;

  typedef logic signed [A_WIDTH-1:0] a_t;
  typedef logic signed [B_WIDTH-1:0] b_t;
  typedef logic signed [P_WIDTH-1:0] p_t;

endpackage

// File: rtl/dsp_negedge_in_reg.sv
// Falling-edge input register stage: captures A, B and the add/subtract mode together
// so the mode stays aligned with the product it applies to.
module dsp_negedge_in_reg
  import dsp_mac_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [A_WIDTH-1:0] a,
  input  logic signed [B_WIDTH-1:0] b,
  input  logic                      sub,
  output logic signed [A_WIDTH-1:0] a_r,
  output logic signed [B_WIDTH-1:0] b_r,
  output logic                      sub_r
);

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      a_r   <= '0;
      b_r   <= '0;
      sub_r <= 1'b0;
    end else begin
      a_r   <= a;
      b_r   <= b;
      sub_r <= sub;
    end
  end

endmodule

// File: rtl/dsp_mul_signed_reg_accum_out_not_reg.sv
// Falling-edge signed multiply-accumulate: registered operands feed a wrapping
// accumulator whose register drives P directly.
module dsp_mul_signed_reg_accum_out_not_reg
  import dsp_mac_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      subtract_i,
  input  logic signed [A_WIDTH-1:0] A,
  input  logic signed [B_WIDTH-1:0] B,
  output logic signed [P_WIDTH-1:0] P
);

  a_t   a_r;
  b_t   b_r;
  logic sub_r;
  p_t   prod;
  p_t   acc;

  dsp_negedge_in_reg u_in_reg (
    .clk   (clk),
    .reset (reset),
    .a     (A),
    .b     (B),
    .sub   (subtract_i),
    .a_r   (a_r),
    .b_r   (b_r),
    .sub_r (sub_r)
  );

  // Both operands sign-extend to the full width first, so the product is exact.
  assign prod = p_t'(a_r) * p_t'(b_r);

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else begin
      acc <= sub_r ? acc - prod : acc + prod;
    end
  end

  assign P = acc;

endmodule

// File: tb/tb_dsp_mul_signed_reg_accum_out_not_reg.sv
// Bench for the falling-edge signed MAC: directed vector table plus randomized
// accumulate/subtract runs checked through a scoreboard queue.
module tb_dsp_mul_signed_reg_accum_out_not_reg;
  import dsp_mac_pkg::*;

  logic clk        = 1'b0;
  logic reset      = 1'b1;
  logic subtract_i = 1'b0;
  a_t   A          = '0;
  b_t   B          = '0;
  p_t   P;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model state
  p_t   m_acc = '0;
  a_t   m_a   = '0;
  b_t   m_b   = '0;
  logic m_s   = 1'b0;

  p_t sb[$];

  typedef struct {
    logic rst;
    a_t   a;
    b_t   b;
    logic s;
    p_t   exp;
  } vec_t;

  vec_t tbl[$];

  dsp_mul_signed_reg_accum_out_not_reg dut (
    .clk        (clk),
    .reset      (reset),
    .subtract_i (subtract_i),
    .A          (A),
    .B          (B),
    .P          (P)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input p_t got, input p_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: P=%0d expected %0d", name, got, exp);
    end
  endtask

  // Drive one set of inputs, let one falling edge pass, check P after it and
  // again after the following rising edge (which must not change anything).
  task automatic step(input logic rst, input a_t a, input b_t b, input logic s,
                      input logic use_exp, input p_t exp_in, input string name);
    p_t prod;
    p_t e;
    reset      = rst;
    A          = a;
    B          = b;
    subtract_i = s;
    prod = p_t'(m_a) * p_t'(m_b);
    if (rst) e = '0;
    else     e = m_s ? m_acc - prod : m_acc + prod;
    sb.push_back(use_exp ? exp_in : e);
    @(negedge clk);
    if (rst) begin
      m_acc = '0; m_a = '0; m_b = '0; m_s = 1'b0;
    end else begin
      m_acc = e; m_a = a; m_b = b; m_s = s;
    end
    #1;
    if (sb.size() == 0) begin
      check({name, "_empty"}, P, 'x);
    end else begin
      e = sb.pop_front();
      check(name, P, e);
      @(posedge clk);
      #1;
      check({name, "_rise"}, P, e);
    end
  endtask

  function automatic vec_t mk(input logic rst, input int a, input int b,
                              input logic s, input longint exp);
    vec_t v;
    v.rst = rst;
    v.a   = a_t'(a);
    v.b   = b_t'(b);
    v.s   = s;
    v.exp = p_t'(exp);
    return v;
  endfunction

  initial begin
    a_t ra;
    b_t rb;

    // Reset
    tbl.push_back(mk(1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0));
    // Add directed: 2-edge latency then +10 per edge
    tbl.push_back(mk(0, 5, 2, 0, 0));
    tbl.push_back(mk(0, 5, 2, 0, 10));
    tbl.push_back(mk(0, 5, 2, 0, 20));
    tbl.push_back(mk(0, 0, 0, 0, 30));
    tbl.push_back(mk(0, 0, 0, 0, 30));
    // Subtract directed
    tbl.push_back(mk(1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 5, 2, 1, 0));
    tbl.push_back(mk(0, 5, 2, 1, -10));
    tbl.push_back(mk(0, 5, 2, 1, -20));
    tbl.push_back(mk(0, 0, 0, 1, -30));
    // Mode toggle mid-stream lands two edges later
    tbl.push_back(mk(1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3, 4, 0, 0));
    tbl.push_back(mk(0, 3, 4, 0, 12));
    tbl.push_back(mk(0, 3, 4, 1, 24));
    tbl.push_back(mk(0, 3, 4, 1, 12));
    tbl.push_back(mk(0, 3, 4, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 12));
    tbl.push_back(mk(0, 0, 0, 0, 12));
    // Most-negative operands: product +2^36, wraps past 2^37-1
    tbl.push_back(mk(1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0));
    tbl.push_back(mk(0, -524288, -131072, 0, 0));
    tbl.push_back(mk(0, -524288, -131072, 0, 64'sd68719476736));
    tbl.push_back(mk(0, -524288, -131072, 0, -64'sd137438953472));
    tbl.push_back(mk(0, -524288, -131072, 0, -64'sd68719476736));
    tbl.push_back(mk(0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].rst, tbl[i].a, tbl[i].b, tbl[i].s, 1'b1, tbl[i].exp,
           $sformatf("vec%0d", i));

    // Random add run
    step(1, '0, '0, 0, 1'b0, '0, "radd_rst0");
    step(1, '0, '0, 0, 1'b0, '0, "radd_rst1");
    do ra = a_t'($urandom); while (ra == '0);
    do rb = b_t'($urandom); while (rb == '0);
    for (int i = 0; i < 32; i++)
      step(0, ra, rb, 0, 1'b0, '0, $sformatf("radd%0d", i));

    // Asynchronous reset mid-accumulation, no clock edge involved
    #2;
    reset = 1'b1;
    #1;
    check("async_rst", P, '0);
    m_acc = '0; m_a = '0; m_b = '0; m_s = 1'b0;
    step(1, '0, '0, 1, 1'b0, '0, "rsub_rst0");
    step(1, '0, '0, 1, 1'b0, '0, "rsub_rst1");

    // Random subtract run, operands forced negative
    do ra = a_t'($urandom); while (ra == '0);
    do rb = b_t'($urandom); while (rb == '0);
    if (ra > 0) ra = -ra;
    if (rb > 0) rb = -rb;
    for (int i = 0; i < 32; i++)
      step(0, ra, rb, 1, 1'b0, '0, $sformatf("rsub%0d", i));

    // Random mixed-sign, mixed-mode run
    for (int i = 0; i < 16; i++)
      step(0, a_t'($urandom), b_t'($urandom), 1'($urandom), 1'b0, '0,
           $sformatf("rmix%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
